cpu_single_cycle: RTL and testbench

- 16-bit single-cycle CPU: eight 16-bit GPRs (r0-r7), a carry flag and a PC.
- Executes one instruction per clk from a 20-word instruction ROM supplied on ports.
- 20-word data RAM is loaded from ports at reset.
- Top-level compute block; all register contents are exported for observation.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cpu_regfile.sv | 32 +++
 rtl/cpu_single_cycle.sv | 154 +++++++++++++++
 tb/tb_cpu_single_cycle.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU: opcodes, instruction field
// positions and memory depths.
package cpu_pkg;

  localparam int IMEM_WORDS = 20;
  localparam int DMEM_WORDS = 20;
  localparam int NUM_REGS   = 8;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 5;
  localparam int IMM8_MSB = 7;
  localparam int IMM5_MSB = 4;
  localparam int OFF_MSB  = 10;

  localparam logic [4:0] OP_ADDI = 5'b00000;
  localparam logic [4:0] OP_ADDR = 5'b00001;
  localparam logic [4:0] OP_SUBR = 5'b00010;
  localparam logic [4:0] OP_ANDR = 5'b00011;
  localparam logic [4:0] OP_ORR  = 5'b00100;
  localparam logic [4:0] OP_LI   = 5'b01100;
  localparam logic [4:0] OP_LR   = 5'b01101;
  localparam logic [4:0] OP_SW   = 5'b01110;
  localparam logic [4:0] OP_LA   = 5'b01111;
  localparam logic [4:0] OP_J    = 5'b10000;
  localparam logic [4:0] OP_JC   = 5'b10011;
  localparam logic [4:0] OP_JNC  = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b11000;
  localparam logic [4:0] OP_JR   = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // Fetches past the end of the ROM see this word, which decodes as halt.
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8x16 general-purpose register file: two combinational read ports,
// one write port, synchronous active-low reset, all registers exported.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [2:0]                 ra_a_i,
  output logic [15:0]                rdata_a_o,
  input  logic [2:0]                 ra_b_i,
  output logic [15:0]                rdata_b_o,
  input  logic                       we_i,
  input  logic [2:0]                 wa_i,
  input  logic [15:0]                wdata_i,
  output logic [NUM_REGS-1:0][15:0]  regs_o
);

  logic [NUM_REGS-1:0][15:0] regs_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[ra_a_i];
  assign rdata_b_o = regs_q[ra_b_i];
  assign regs_o    = regs_q;

endmodule

// File: rtl/cpu_single_cycle.sv
// 16-bit single-cycle CPU: fetch from port-supplied ROM, decode, ALU, PC
// update and a 20-word data RAM reloaded from ports on reset.
module cpu_single_cycle
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irom_mem0,  input logic [15:0] irom_mem1,
  input  logic [15:0] irom_mem2,  input logic [15:0] irom_mem3,
  input  logic [15:0] irom_mem4,  input logic [15:0] irom_mem5,
  input  logic [15:0] irom_mem6,  input logic [15:0] irom_mem7,
  input  logic [15:0] irom_mem8,  input logic [15:0] irom_mem9,
  input  logic [15:0] irom_mem10, input logic [15:0] irom_mem11,
  input  logic [15:0] irom_mem12, input logic [15:0] irom_mem13,
  input  logic [15:0] irom_mem14, input logic [15:0] irom_mem15,
  input  logic [15:0] irom_mem16, input logic [15:0] irom_mem17,
  input  logic [15:0] irom_mem18, input logic [15:0] irom_mem19,
  input  logic [15:0] drom_mem0,  input logic [15:0] drom_mem1,
  input  logic [15:0] drom_mem2,  input logic [15:0] drom_mem3,
  input  logic [15:0] drom_mem4,  input logic [15:0] drom_mem5,
  input  logic [15:0] drom_mem6,  input logic [15:0] drom_mem7,
  input  logic [15:0] drom_mem8,  input logic [15:0] drom_mem9,
  input  logic [15:0] drom_mem10, input logic [15:0] drom_mem11,
  input  logic [15:0] drom_mem12, input logic [15:0] drom_mem13,
  input  logic [15:0] drom_mem14, input logic [15:0] drom_mem15,
  input  logic [15:0] drom_mem16, input logic [15:0] drom_mem17,
  input  logic [15:0] drom_mem18, input logic [15:0] drom_mem19,
  output logic [15:0] r0, output logic [15:0] r1,
  output logic [15:0] r2, output logic [15:0] r3,
  output logic [15:0] r4, output logic [15:0] r5,
  output logic [15:0] r6, output logic [15:0] r7
);

  logic [15:0] irom [IMEM_WORDS];
  logic [15:0] drom [DMEM_WORDS];

  assign irom = '{irom_mem0, irom_mem1, irom_mem2, irom_mem3, irom_mem4,
                  irom_mem5, irom_mem6, irom_mem7, irom_mem8, irom_mem9,
                  irom_mem10, irom_mem11, irom_mem12, irom_mem13, irom_mem14,
                  irom_mem15, irom_mem16, irom_mem17, irom_mem18, irom_mem19};
  assign drom = '{drom_mem0, drom_mem1, drom_mem2, drom_mem3, drom_mem4,
                  drom_mem5, drom_mem6, drom_mem7, drom_mem8, drom_mem9,
                  drom_mem10, drom_mem11, drom_mem12, drom_mem13, drom_mem14,
                  drom_mem15, drom_mem16, drom_mem17, drom_mem18, drom_mem19};

  logic [15:0] pc_q, pc_d;
  logic        c_q, c_d;
  logic [15:0] dmem_q [DMEM_WORDS];

  logic [15:0] instr;
  logic [4:0]  op;
  logic [2:0]  rd_idx, rs_idx;
  logic [15:0] rd_val, rs_val;
  logic [15:0] imm8_z, imm8_s, off11_s;
  logic [15:0] daddr, load_data;
  logic        d_in_range;
  logic        rf_we, mem_we;
  logic [15:0] rf_wd;
  logic [16:0] sum17;
  logic [NUM_REGS-1:0][15:0] regs;

  assign instr   = (pc_q < 16'(IMEM_WORDS)) ? irom[pc_q[4:0]] : HALT_WORD;
  assign op      = instr[OP_MSB:OP_LSB];
  assign rd_idx  = instr[RD_MSB:RD_LSB];
  assign rs_idx  = instr[RS_MSB:RS_LSB];
  assign imm8_z  = {8'h00, instr[IMM8_MSB:0]};
  assign imm8_s  = {{8{instr[IMM8_MSB]}}, instr[IMM8_MSB:0]};
  assign off11_s = {{5{instr[OFF_MSB]}}, instr[OFF_MSB:0]};

  // Data addresses wrap at 16 bits; anything past the RAM reads 0 and drops writes.
  assign daddr      = rs_val + sext5(instr[IMM5_MSB:0]);
  assign d_in_range = daddr < 16'(DMEM_WORDS);
  assign load_data  = d_in_range ? dmem_q[daddr[4:0]] : 16'h0000;

  cpu_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst),
    .ra_a_i    (rd_idx),
    .rdata_a_o (rd_val),
    .ra_b_i    (rs_idx),
    .rdata_b_o (rs_val),
    .we_i      (rf_we),
    .wa_i      (rd_idx),
    .wdata_i   (rf_wd),
    .regs_o    (regs)
  );

  always_comb begin
    pc_d   = pc_q + 16'd1;
    c_d    = c_q;
    rf_we  = 1'b0;
    rf_wd  = 16'h0000;
    mem_we = 1'b0;
    sum17  = 17'h0;
    case (op)
      OP_ADDI: begin
        sum17 = {1'b0, rd_val} + {1'b0, imm8_z};
        rf_we = 1'b1; rf_wd = sum17[15:0]; c_d = sum17[16];
      end
      OP_ADDR: begin
        sum17 = {1'b0, rd_val} + {1'b0, rs_val};
        rf_we = 1'b1; rf_wd = sum17[15:0]; c_d = sum17[16];
      end
      OP_SUBR: begin
        // Bit 16 of the widened difference is the borrow (rd < rs unsigned).
        sum17 = {1'b0, rd_val} - {1'b0, rs_val};
        rf_we = 1'b1; rf_wd = sum17[15:0]; c_d = sum17[16];
      end
      OP_ANDR: begin rf_we = 1'b1; rf_wd = rd_val & rs_val; end
      OP_ORR:  begin rf_we = 1'b1; rf_wd = rd_val | rs_val; end
      OP_LI:   begin rf_we = 1'b1; rf_wd = imm8_z; end
      OP_LR:   begin rf_we = 1'b1; rf_wd = rs_val; end
      OP_SW:   mem_we = d_in_range;
      OP_LA:   begin rf_we = 1'b1; rf_wd = load_data; end
      OP_J:    pc_d = pc_q + off11_s;
      OP_JC:   if (c_q) pc_d = pc_q + off11_s;
      OP_JNC:  if (!c_q) pc_d = pc_q + off11_s;
      OP_JAL: begin
        rf_we = 1'b1; rf_wd = pc_q + 16'd1; pc_d = pc_q + imm8_s;
      end
      OP_JR:   pc_d = rd_val;
      OP_HALT: pc_d = pc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= 16'h0000;
      c_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      c_q  <= c_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= drom[i];
    end else if (mem_we) begin
      dmem_q[daddr[4:0]] <= rd_val;
    end
  end

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];

endmodule

// File: tb/tb_cpu_single_cycle.sv
// Bench for cpu_single_cycle: directed tables, hand sequences and random
// programs checked against an instruction-level model.
module tb_cpu_single_cycle;

  localparam logic [4:0] ADDI = 5'd0,  ADDR = 5'd1,  SUBR = 5'd2,  ANDR = 5'd3;
  localparam logic [4:0] ORR  = 5'd4,  LI   = 5'd12, LR   = 5'd13, SW   = 5'd14;
  localparam logic [4:0] LA   = 5'd15, J    = 5'd16, JC   = 5'd19, JNC  = 5'd20;
  localparam logic [4:0] JAL  = 5'd24, JR   = 5'd26;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] irom [20];
  logic [15:0] drom [20];
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

  int n_pass = 0;
  int n_total = 0;

  int m_r [8];
  int m_pc, m_c;
  int m_mem [20];

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_r1;
    logic        exp_c;
  } alu_vec_t;

  // kind: 0 = GPR, 1 = PC, 2 = carry, 3 = data RAM word
  typedef struct {
    string name;
    int    kind;
    int    idx;
    int    exp;
  } obs_vec_t;

  alu_vec_t alu_vecs [9];
  obs_vec_t ref_vecs [11];

  cpu_single_cycle dut (
    .clk(clk), .rst(rst),
    .irom_mem0(irom[0]),   .irom_mem1(irom[1]),   .irom_mem2(irom[2]),   .irom_mem3(irom[3]),
    .irom_mem4(irom[4]),   .irom_mem5(irom[5]),   .irom_mem6(irom[6]),   .irom_mem7(irom[7]),
    .irom_mem8(irom[8]),   .irom_mem9(irom[9]),   .irom_mem10(irom[10]), .irom_mem11(irom[11]),
    .irom_mem12(irom[12]), .irom_mem13(irom[13]), .irom_mem14(irom[14]), .irom_mem15(irom[15]),
    .irom_mem16(irom[16]), .irom_mem17(irom[17]), .irom_mem18(irom[18]), .irom_mem19(irom[19]),
    .drom_mem0(drom[0]),   .drom_mem1(drom[1]),   .drom_mem2(drom[2]),   .drom_mem3(drom[3]),
    .drom_mem4(drom[4]),   .drom_mem5(drom[5]),   .drom_mem6(drom[6]),   .drom_mem7(drom[7]),
    .drom_mem8(drom[8]),   .drom_mem9(drom[9]),   .drom_mem10(drom[10]), .drom_mem11(drom[11]),
    .drom_mem12(drom[12]), .drom_mem13(drom[13]), .drom_mem14(drom[14]), .drom_mem15(drom[15]),
    .drom_mem16(drom[16]), .drom_mem17(drom[17]), .drom_mem18(drom[18]), .drom_mem19(drom[19]),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [15:0] enc_i(input logic [4:0] op, input int rd, input int imm);
    logic [15:0] w;
    logic [2:0]  rdb;
    logic [7:0]  ib;
    rdb = 3'(rd);
    ib  = 8'(imm);
    w = {op, rdb, ib};
    return w;
  endfunction

  function automatic logic [15:0] enc_r(input logic [4:0] op, input int rd, input int rs, input int imm5);
    logic [15:0] w;
    logic [2:0]  rdb, rsb;
    logic [4:0]  ib;
    rdb = 3'(rd);
    rsb = 3'(rs);
    ib  = 5'(imm5);
    w = {op, rdb, rsb, ib};
    return w;
  endfunction

  function automatic logic [15:0] enc_j(input logic [4:0] op, input int off);
    logic [10:0] ob;
    ob = 11'(off);
    return {op, ob};
  endfunction

  // ---------------- observation ----------------
  function automatic int dut_reg(input int i);
    case (i)
      0: return int'(r0);
      1: return int'(r1);
      2: return int'(r2);
      3: return int'(r3);
      4: return int'(r4);
      5: return int'(r5);
      6: return int'(r6);
      default: return int'(r7);
    endcase
  endfunction

  function automatic int dut_obs(input int kind, input int idx);
    case (kind)
      0: return dut_reg(idx);
      1: return int'(dut.pc_q);
      2: return int'(dut.c_q);
      default: return int'(dut.dmem_q[idx]);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    for (int i = 0; i < 20; i++) m_mem[i] = int'(drom[i]);
    m_pc = 0;
    m_c  = 0;
  endtask

  task automatic model_step();
    logic [15:0] ins;
    int op, rd, rs, imm8, s5, s8, off, rdv, rsv, addr, nxt, sum;
    ins  = (m_pc < 20) ? irom[m_pc] : 16'hFFFF;
    op   = int'(ins[15:11]);
    rd   = int'(ins[10:8]);
    rs   = int'(ins[7:5]);
    imm8 = int'(ins[7:0]);
    s5   = int'(ins[4:0]);  if (s5 > 15) s5 -= 32;
    s8   = imm8;            if (s8 > 127) s8 -= 256;
    off  = int'(ins[10:0]); if (off > 1023) off -= 2048;
    rdv  = m_r[rd];
    rsv  = m_r[rs];
    addr = (rsv + s5) & 'hFFFF;
    nxt  = (m_pc + 1) & 'hFFFF;
    case (op)
      0:  begin sum = rdv + imm8; m_r[rd] = sum & 'hFFFF; m_c = (sum > 'hFFFF) ? 1 : 0; end
      1:  begin sum = rdv + rsv;  m_r[rd] = sum & 'hFFFF; m_c = (sum > 'hFFFF) ? 1 : 0; end
      2:  begin m_r[rd] = (rdv - rsv) & 'hFFFF; m_c = (rdv < rsv) ? 1 : 0; end
      3:  m_r[rd] = rdv & rsv;
      4:  m_r[rd] = rdv | rsv;
      12: m_r[rd] = imm8;
      13: m_r[rd] = rsv;
      14: if (addr < 20) m_mem[addr] = rdv;
      15: m_r[rd] = (addr < 20) ? m_mem[addr] : 0;
      16: nxt = (m_pc + off) & 'hFFFF;
      19: if (m_c == 1) nxt = (m_pc + off) & 'hFFFF;
      20: if (m_c == 0) nxt = (m_pc + off) & 'hFFFF;
      24: begin m_r[rd] = (m_pc + 1) & 'hFFFF; nxt = (m_pc + s8) & 'hFFFF; end
      26: nxt = rdv;
      31: nxt = m_pc;
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic run(input int n, input bit chk_pc, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      model_step();
      if (chk_pc) check($sformatf("%s_pc_c%0d", tag, k), int'(dut.pc_q), m_pc);
    end
  endtask

  task automatic compare_state(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), dut_reg(i), m_r[i]);
    check({tag, "_pc"}, int'(dut.pc_q), m_pc);
    check({tag, "_c"}, int'(dut.c_q), m_c);
    for (int i = 0; i < 20; i++) check($sformatf("%s_mem%0d", tag, i), int'(dut.dmem_q[i]), m_mem[i]);
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 20; i++) irom[i] = w;
  endtask

  task automatic load_ref_prog();
    fill_rom(HALT);
    irom[0]  = enc_i(LI, 0, 36);
    irom[1]  = enc_r(LR, 1, 0, 0);
    irom[2]  = enc_r(ADDR, 1, 0, 0);
    irom[3]  = enc_i(LI, 3, 0);
    irom[4]  = enc_r(SW, 1, 3, 0);
    irom[5]  = enc_r(LA, 4, 3, 2);
    irom[6]  = enc_i(JAL, 7, 4);
    irom[7]  = HALT;
    irom[8]  = enc_j(J, 5);
    irom[9]  = enc_j(J, 4);
    irom[10] = enc_i(ADDI, 4, 25);
    irom[11] = enc_j(JC, -3);
    irom[12] = enc_j(JNC, 2);
    irom[13] = HALT;
    irom[14] = enc_r(JR, 7, 0, 0);
    for (int i = 0; i < 20; i++) drom[i] = 16'h0000;
    drom[0] = 16'd255; drom[1] = 16'd322; drom[2] = 16'd10;  drom[3] = 16'd55;
    drom[4] = 16'd216; drom[5] = 16'd228; drom[6] = 16'd33;  drom[7] = 16'd2;
  endtask

  task automatic check_ref_table(input string tag);
    for (int i = 0; i < 11; i++)
      check({tag, "_", ref_vecs[i].name}, dut_obs(ref_vecs[i].kind, ref_vecs[i].idx), ref_vecs[i].exp);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    alu_vecs[0] = '{"addr_wrap",  ADDR, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    alu_vecs[1] = '{"addr_plain", ADDR, 16'h1234, 16'h0101, 16'h1335, 1'b0};
    alu_vecs[2] = '{"subr_borrow",SUBR, 16'h0003, 16'h0005, 16'hFFFE, 1'b1};
    alu_vecs[3] = '{"subr_plain", SUBR, 16'h0005, 16'h0003, 16'h0002, 1'b0};
    alu_vecs[4] = '{"subr_equal", SUBR, 16'h8000, 16'h8000, 16'h0000, 1'b0};
    alu_vecs[5] = '{"andr",       ANDR, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    alu_vecs[6] = '{"orr",        ORR,  16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0};
    alu_vecs[7] = '{"addi_wrap",  ADDI, 16'hFF01, 16'h00FF, 16'h0000, 1'b1};
    alu_vecs[8] = '{"addi_zext",  ADDI, 16'h1000, 16'h0080, 16'h1080, 1'b0};

    ref_vecs[0]  = '{"r0", 0, 0, 36};
    ref_vecs[1]  = '{"r1", 0, 1, 72};
    ref_vecs[2]  = '{"r2", 0, 2, 0};
    ref_vecs[3]  = '{"r3", 0, 3, 0};
    ref_vecs[4]  = '{"r4", 0, 4, 35};
    ref_vecs[5]  = '{"r5", 0, 5, 0};
    ref_vecs[6]  = '{"r6", 0, 6, 0};
    ref_vecs[7]  = '{"r7", 0, 7, 7};
    ref_vecs[8]  = '{"pc", 1, 0, 7};
    ref_vecs[9]  = '{"c",  2, 0, 0};
    ref_vecs[10] = '{"mem0", 3, 0, 72};

    // Reset with arbitrary ROM, then instruction 0 runs on the first edge.
    for (int i = 0; i < 20; i++) begin
      irom[i] = 16'($urandom);
      drom[i] = 16'($urandom);
    end
    do_reset(5);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), dut_reg(i), 0);
    check("rst_pc", int'(dut.pc_q), 0);
    check("rst_c", int'(dut.c_q), 0);
    check("rst_mem3", int'(dut.dmem_q[3]), int'(drom[3]));
    irom[0] = enc_i(LI, 2, 8'h5A);
    rst = 1'b1;
    tick();
    check("first_edge_r2", int'(r2), 16'h005A);
    check("first_edge_pc", int'(dut.pc_q), 1);

    // ALU vector table: operands loaded from data RAM.
    for (int v = 0; v < 9; v++) begin
      fill_rom(HALT);
      for (int i = 0; i < 20; i++) drom[i] = 16'h0000;
      drom[0] = alu_vecs[v].a;
      drom[1] = alu_vecs[v].b;
      irom[0] = enc_i(LI, 3, 0);
      irom[1] = enc_r(LA, 1, 3, 0);
      irom[2] = enc_r(LA, 2, 3, 1);
      if (alu_vecs[v].op == ADDI) irom[3] = enc_i(ADDI, 1, int'(alu_vecs[v].b[7:0]));
      else                        irom[3] = enc_r(alu_vecs[v].op, 1, 2, 0);
      do_reset(1);
      run(5, 1'b0, "alu");
      check({alu_vecs[v].name, "_r1"}, int'(r1), int'(alu_vecs[v].exp_r1));
      check({alu_vecs[v].name, "_c"}, int'(dut.c_q), int'(alu_vecs[v].exp_c));
    end

    // Reference program.
    load_ref_prog();
    do_reset(2);
    run(12, 1'b0, "ref");
    check_ref_table("ref");
    run(6, 1'b0, "ref_hold");
    check("ref_pc_held", int'(dut.pc_q), 7);
    compare_state("ref_model");

    // Carry path.
    fill_rom(HALT);
    for (int i = 0; i < 20; i++) drom[i] = 16'h0000;
    drom[0] = 16'hFFFF;
    irom[0] = enc_i(LI, 3, 0);
    irom[1] = enc_r(LA, 2, 3, 0);
    irom[2] = enc_i(ADDI, 2, 1);
    irom[3] = enc_j(JC, 2);
    irom[4] = enc_i(LI, 5, 1);
    do_reset(1);
    run(8, 1'b0, "carry");
    check("carry_r2", int'(r2), 0);
    check("carry_c", int'(dut.c_q), 1);
    check("carry_r5", int'(r5), 0);

    // Subtract / borrow / logic.
    fill_rom(HALT);
    irom[0] = enc_i(LI, 1, 3);
    irom[1] = enc_i(LI, 2, 5);
    irom[2] = enc_r(SUBR, 1, 2, 0);
    irom[3] = enc_j(JNC, 2);
    irom[4] = enc_i(LI, 6, 9);
    irom[5] = enc_r(ANDR, 2, 1, 0);
    do_reset(1);
    run(8, 1'b0, "sub");
    check("sub_r1", int'(r1), 16'hFFFE);
    check("sub_r6", int'(r6), 9);
    check("sub_r2", int'(r2), 16'h0004);
    check("sub_c", int'(dut.c_q), 1);

    // Out-of-range data accesses, including a wrapped negative address.
    fill_rom(HALT);
    for (int i = 0; i < 20; i++) drom[i] = 16'(100 + i);
    irom[0] = enc_i(LI, 3, 25);
    irom[1] = enc_i(LI, 1, 8'h77);
    irom[2] = enc_i(LI, 2, 5);
    irom[3] = enc_r(SW, 1, 3, 0);
    irom[4] = enc_r(LA, 2, 3, 0);
    irom[5] = enc_r(SW, 1, 0, -1);
    irom[6] = enc_i(LI, 4, 5);
    irom[7] = enc_r(LA, 4, 0, -1);
    do_reset(1);
    run(10, 1'b0, "bounds");
    check("bounds_la25", int'(r2), 0);
    check("bounds_la_wrap", int'(r4), 0);
    for (int i = 0; i < 20; i++)
      check($sformatf("bounds_mem%0d", i), int'(dut.dmem_q[i]), 100 + i);

    // Running off the end of the ROM halts at PC=20.
    fill_rom(16'h2800);
    do_reset(1);
    run(25, 1'b0, "runoff");
    check("runoff_pc", int'(dut.pc_q), 20);
    run(3, 1'b0, "runoff_hold");
    check("runoff_pc_held", int'(dut.pc_q), 20);

    // Reset in the middle of the reference program.
    load_ref_prog();
    do_reset(1);
    run(5, 1'b0, "mid");
    check("mid_mem0_before", int'(dut.dmem_q[0]), 72);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) check($sformatf("mid_rst_r%0d", i), dut_reg(i), 0);
    check("mid_rst_pc", int'(dut.pc_q), 0);
    check("mid_mem0_reload", int'(dut.dmem_q[0]), 255);
    run(12, 1'b0, "mid_rerun");
    check_ref_table("mid_rerun");

    // Random programs against the model.
    for (int p = 0; p < 15; p++) begin
      int ops [16] = '{0, 1, 2, 3, 4, 12, 13, 14, 15, 16, 19, 20, 24, 26, 31, 5};
      for (int i = 0; i < 20; i++) begin
        logic [4:0]  o;
        logic [10:0] rest;
        o    = 5'(ops[$urandom_range(0, 15)]);
        rest = 11'($urandom);
        irom[i] = {o, rest};
        drom[i] = 16'($urandom);
      end
      do_reset(1);
      run(40, 1'b1, $sformatf("rnd%0d", p));
      compare_state($sformatf("rnd%0d", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
